// File: rtl/intra_sched_pkg.sv
// Shared types, codes and helpers for the intra prediction block scheduler.
package intra_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StExtract,
    StWaitExt,
    StPredict,
    StAdvance,
    StDone
  } sched_state_e;

  localparam logic [1:0] SZ_4X4   = 2'd0;
  localparam logic [1:0] SZ_8X8   = 2'd1;
  localparam logic [1:0] SZ_16X16 = 2'd2;

  localparam logic [1:0] PL_Y  = 2'd0;
  localparam logic [1:0] PL_CB = 2'd1;
  localparam logic [1:0] PL_CR = 2'd2;

  // Pixel offset of a 4x4 luma sub-block inside its MB, H.264 decoding order.
  // Returns {y[3:0], x[3:0]}.
  function automatic logic [7:0] blk4_offset(input logic [3:0] blk);
    return {blk[3], blk[1], 2'b00, blk[2], blk[0], 2'b00};
  endfunction

endpackage

// File: rtl/intra_block_scheduler_if.sv
// Control/descriptor bundle between the scheduler and its extractor/predictor.
interface intra_block_scheduler_if;
  logic        start;
  logic        mode_4x4;
  logic        pred_done;
  logic        ext_enable;
  logic [31:0] ext_mbnumber;
  logic [1:0]  ext_size;
  logic [1:0]  ext_plane;
  logic        pred_start;
  logic        busy;
  logic        frame_done;

  // Scheduler side.
  modport master (
    input  start, mode_4x4, pred_done,
    output ext_enable, ext_mbnumber, ext_size, ext_plane, pred_start, busy, frame_done
  );

  // Environment side (frame control, extractor, predictor).
  modport slave (
    output start, mode_4x4, pred_done,
    input  ext_enable, ext_mbnumber, ext_size, ext_plane, pred_start, busy, frame_done
  );
endinterface

// File: rtl/mb_raster_counter.sv
// Macroblock position counter walking the picture in raster order.
module mb_raster_counter #(
  parameter int unsigned MbCols = 80,
  parameter int unsigned MbRows = 45
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_i,
  input  logic        clear_i,
  output logic [15:0] mb_x_o,
  output logic [15:0] mb_y_o,
  output logic [15:0] mb_x_nxt_o,
  output logic [15:0] mb_y_nxt_o,
  output logic        last_mb_o
);

  localparam logic [15:0] LastCol = 16'(MbCols - 1);
  localparam logic [15:0] LastRow = 16'(MbRows - 1);

  logic [15:0] mb_x_q, mb_x_d, mb_y_q, mb_y_d;
  logic        wrap;

  // Position after one step; exposed so the parent can register the next descriptor.
  always_comb begin
    wrap       = (mb_x_q == LastCol);
    mb_x_nxt_o = wrap ? 16'd0 : mb_x_q + 16'd1;
    mb_y_nxt_o = mb_y_q;
    if (wrap) mb_y_nxt_o = (mb_y_q == LastRow) ? 16'd0 : mb_y_q + 16'd1;
    mb_x_d = mb_x_q;
    mb_y_d = mb_y_q;
    if (clear_i) begin
      mb_x_d = 16'd0;
      mb_y_d = 16'd0;
    end else if (step_i) begin
      mb_x_d = mb_x_nxt_o;
      mb_y_d = mb_y_nxt_o;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mb_x_q <= 16'd0;
      mb_y_q <= 16'd0;
    end else begin
      mb_x_q <= mb_x_d;
      mb_y_q <= mb_y_d;
    end
  end

  assign mb_x_o    = mb_x_q;
  assign mb_y_o    = mb_y_q;
  assign last_mb_o = (mb_x_q == LastCol) && (mb_y_q == LastRow);

endmodule

// File: rtl/intra_block_scheduler.sv
// Frame-level intra prediction sequencer: MB raster walk, luma/chroma block order,
// extractor enable + latency wait, predictor start/done handshake.
module intra_block_scheduler
  import intra_sched_pkg::*;
#(
  parameter int unsigned PIC_W     = 1280,
  parameter int unsigned PIC_H     = 720,
  parameter int unsigned EXT_LAT   = 1,
  parameter int unsigned CHROMA_EN = 1
) (
  input logic                     clk,
  input logic                     reset,
  intra_block_scheduler_if.master bus
);

  localparam int unsigned MbCols = PIC_W / 16;
  localparam int unsigned MbRows = PIC_H / 16;

  sched_state_e state_q, state_d;
  logic         mode4_q, mode4_d;
  logic [3:0]   blk_q, blk_d;
  logic [1:0]   plane_q, plane_d;
  logic [3:0]   lat_q, lat_d;
  logic         busy_q, busy_d;
  logic         pred_start_q, pred_start_d;
  logic [31:0]  mbn_q, mbn_d;
  logic [1:0]   size_q, size_d;

  logic [15:0]  mb_x, mb_y, mb_x_nxt, mb_y_nxt;
  logic         last_mb, cnt_step, cnt_clear;

  mb_raster_counter #(
    .MbCols (MbCols),
    .MbRows (MbRows)
  ) u_raster (
    .clk        (clk),
    .reset      (reset),
    .step_i     (cnt_step),
    .clear_i    (cnt_clear),
    .mb_x_o     (mb_x),
    .mb_y_o     (mb_y),
    .mb_x_nxt_o (mb_x_nxt),
    .mb_y_nxt_o (mb_y_nxt),
    .last_mb_o  (last_mb)
  );

  // Candidate descriptors for the block that follows the current one.
  logic [3:0]  blk_nxt;
  logic [7:0]  blk_off;
  logic [31:0] sub_mbn, chroma_mbn, next_mb_mbn;
  logic        last_luma;

  assign blk_nxt     = blk_q + 4'd1;
  assign blk_off     = blk4_offset(blk_nxt);
  assign sub_mbn     = {(mb_y << 4) + {12'd0, blk_off[7:4]}, (mb_x << 4) + {12'd0, blk_off[3:0]}};
  assign chroma_mbn  = {mb_y << 3, mb_x << 3};
  assign next_mb_mbn = {mb_y_nxt << 4, mb_x_nxt << 4};
  assign last_luma   = !mode4_q || (blk_q == 4'd15);

  // Next-state, block sequencing and descriptor selection.
  always_comb begin
    state_d      = state_q;
    mode4_d      = mode4_q;
    blk_d        = blk_q;
    plane_d      = plane_q;
    lat_d        = lat_q;
    busy_d       = busy_q;
    pred_start_d = 1'b0;
    mbn_d        = mbn_q;
    size_d       = size_q;
    cnt_step     = 1'b0;
    cnt_clear    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StExtract;
          mode4_d   = bus.mode_4x4;
          busy_d    = 1'b1;
          blk_d     = 4'd0;
          plane_d   = PL_Y;
          cnt_clear = 1'b1;
          mbn_d     = 32'd0;
          size_d    = bus.mode_4x4 ? SZ_4X4 : SZ_16X16;
        end
      end
      StExtract: begin
        state_d = StWaitExt;
        lat_d   = 4'(EXT_LAT);
      end
      StWaitExt: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d      = StPredict;
          pred_start_d = 1'b1;
        end
      end
      StPredict: begin
        if (bus.pred_done) state_d = StAdvance;
      end
      StAdvance: begin
        state_d = StExtract;
        if (plane_q == PL_Y && !last_luma) begin
          blk_d = blk_nxt;
          mbn_d = sub_mbn;
        end else if (plane_q == PL_Y && CHROMA_EN != 0) begin
          plane_d = PL_CB;
          blk_d   = 4'd0;
          mbn_d   = chroma_mbn;
          size_d  = SZ_8X8;
        end else if (plane_q == PL_CB) begin
          plane_d = PL_CR;
        end else if (last_mb) begin
          state_d = StDone;
          busy_d  = 1'b0;
        end else begin
          cnt_step = 1'b1;
          plane_d  = PL_Y;
          blk_d    = 4'd0;
          mbn_d    = next_mb_mbn;
          size_d   = mode4_q ? SZ_4X4 : SZ_16X16;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and descriptor registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      mode4_q      <= 1'b0;
      blk_q        <= 4'd0;
      plane_q      <= PL_Y;
      lat_q        <= 4'd0;
      busy_q       <= 1'b0;
      pred_start_q <= 1'b0;
      mbn_q        <= 32'd0;
      size_q       <= SZ_4X4;
    end else begin
      state_q      <= state_d;
      mode4_q      <= mode4_d;
      blk_q        <= blk_d;
      plane_q      <= plane_d;
      lat_q        <= lat_d;
      busy_q       <= busy_d;
      pred_start_q <= pred_start_d;
      mbn_q        <= mbn_d;
      size_q       <= size_d;
    end
  end

  assign bus.ext_enable   = (state_q == StExtract);
  assign bus.frame_done   = (state_q == StDone);
  assign bus.pred_start   = pred_start_q;
  assign bus.busy         = busy_q;
  assign bus.ext_mbnumber = mbn_q;
  assign bus.ext_size     = size_q;
  assign bus.ext_plane    = plane_q;

endmodule

// File: doc/intra_block_scheduler.md
Name: intra_block_scheduler

Overview:
- Sequences intra prediction over one frame.
- Walks macroblocks in raster order and, per block, generates the packed {row,col} pixel coordinate for the neighbour-pixel extractor.
- Pulses the extractor enable, waits the extractor latency, then starts the predictor and waits for its completion handshake.
- Supports whole-MB 16x16 luma or sixteen 4x4 luma sub-blocks per MB, optionally followed by two 8x8 chroma blocks (Cb, Cr).

Parameters:
PIC_W, 1280, luma picture width in pixels; multiple of 16
PIC_H, 720, luma picture height in pixels; multiple of 16
EXT_LAT, 1, cycles from ext_enable to valid extractor outputs; range 1..15
CHROMA_EN, 1, 1 = schedule Cb and Cr 8x8 blocks after each MB's luma

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  frame start request; sampled in IDLE only
mode_4x4  in  1  luma partition select, latched when start is accepted
pred_done  in  1  predictor completion for the current block
ext_enable  out  1  one-cycle enable to the extractor
ext_mbnumber  out  32  [31:16] block pixel row, [15:0] block pixel column, in plane coordinates
ext_size  out  2  0 = 4x4, 1 = 8x8, 2 = 16x16
ext_plane  out  2  0 = Y, 1 = Cb, 2 = Cr
pred_start  out  1  one-cycle predictor start
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after the last block's pred_done

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; all outputs 0; mb_x, mb_y, blk, and latency counters 0. A reset mid-frame abandons the frame; no frame_done is issued.
- FSM states: IDLE, EXTRACT, WAIT_EXT, PREDICT, ADVANCE, DONE.
- IDLE:
  - start = 1 → EXTRACT; latch mode_4x4; set busy = 1; clear mb_x, mb_y, blk, plane.
  - start is ignored in every other state.
- EXTRACT: ext_enable = 1 for exactly this cycle → WAIT_EXT, with the latency counter loaded to EXT_LAT.
- WAIT_EXT: decrement the counter each cycle; on reaching 0 → PREDICT. Dwell is EXT_LAT cycles.
- PREDICT:
  - pred_start = 1 on the first PREDICT cycle only.
  - Stays in PREDICT until pred_done = 1, then → ADVANCE.
  - pred_done is honoured only in PREDICT, including on the pred_start cycle; it is ignored in all other states.
- ADVANCE, one cycle; block order within an MB:
  - Luma 16x16 mode: a single block.
  - Luma 4x4 mode: blk runs 0..15 in H.264 decoding order. Sub-block x = {blk[2],blk[0]}*4 and y = {blk[3],blk[1]}*4, offset from the MB origin.
  - If CHROMA_EN = 1: Cb then Cr, each 8x8 at (mb_y*8, mb_x*8).
  - After the MB's last block: mb_x++. On wrap (mb_x = PIC_W/16-1), set mb_x = 0 and mb_y++.
  - After the last MB (mb_y = PIC_H/16-1, mb_x = PIC_W/16-1, last block) → DONE; otherwise → EXTRACT.
- DONE: frame_done = 1 for one cycle; busy = 0 → IDLE.
- ext_mbnumber, ext_size and ext_plane:
  - Registered; updated only on the ADVANCE→EXTRACT or IDLE→EXTRACT transition.
  - Stable from EXTRACT through the end of PREDICT.
  - Luma row = mb_y*16 + sub_y and col = mb_x*16 + sub_x, all 16-bit unsigned; the upper 16 bits of ext_mbnumber hold row.
- Cycle cost per block with immediate pred_done: 1 + EXT_LAT + 1 + 1.

Decomposition:
- Package intra_sched_pkg holds:
  - state enum
  - size codes SZ_4X4 = 0, SZ_8X8 = 1, SZ_16X16 = 2
  - plane codes PL_Y = 0, PL_CB = 1, PL_CR = 2
  - function blk4_offset(blk) returning {y,x}
- Sub-module mb_raster_counter: holds mb_x/mb_y, with inputs step and clear and outputs mb_x, mb_y, last_mb.

Test Plan:
- PIC_W = PIC_H = 32, CHROMA_EN = 0, mode_4x4 = 0, pred_done returned one cycle after pred_start:
  - ext_mbnumber sequence is 0x00000000, 0x00000010, 0x00100000, 0x00100010.
  - One frame_done pulse; busy spans the whole frame.
- PIC_W = PIC_H = 16, mode_4x4 = 1:
  - blk coordinates, as (row,col), are (0,0), (0,4), (4,0), (4,4), (0,8), (0,12), (4,8), (4,12), (8,0) … (12,12), all with ext_size = 0.
- CHROMA_EN = 1, PIC_W = 32, PIC_H = 16:
  - After MB(0,1) luma, Cb block at 0x00000008 (ext_plane = 1), then Cr at 0x00000008 (ext_plane = 2).
- EXT_LAT = 3, pred_done held low for 10 cycles:
  - Exactly 3 cycles from ext_enable to pred_start.
  - Outputs stay stable for all 10 cycles.
  - A stray pred_done during WAIT_EXT is ignored.
- Assert reset low mid-PREDICT at MB 2:
  - All outputs are 0 immediately and no frame_done is issued.
  - A later start restarts the frame at 0x00000000.
- Pulse start while busy:
  - Counters are unaffected and there is no extra frame.
  - start asserted in the same cycle as frame_done is ignored; start in the next IDLE cycle is accepted.
